// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D_intf converter between NUM_REQ requesters.
// Optional fixed priority for requester 0 when A2D_ARB_PRIO_EN is defined.
module a2d_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_chnnl,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   done_err,
  output logic [11:0]            res_out,
  output logic                   busy,
  output logic                   a2d_strt_cnv,
  output logic [2:0]             a2d_chnnl,
  input  logic                   a2d_cnv_cmplt,
  input  logic [11:0]            a2d_res
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic [11:0]        res_q, res_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

  logic               win_valid;
  logic [PW-1:0]      win_idx;

  // Winner is the first set request scanning upward from rr_ptr with wrap-around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = PW'(idx);
      end
    end
`ifdef A2D_ARB_PRIO_EN
    if (req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    chnnl_d  = chnnl_q;
    res_d    = res_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          owner_d = win_idx;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          chnnl_d = req_chnnl[3*win_idx +: 3];
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (a2d_cnv_cmplt) begin
          res_d   = a2d_res;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          res_d   = 12'hFFF;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        gnt_d   = '0;
        state_d = S_IDLE;
`ifdef A2D_ARB_PRIO_EN
        if (owner_q != '0) begin
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
        end
`else
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      gnt_q    <= '0;
      chnnl_q  <= 3'b000;
      res_q    <= 12'h000;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      chnnl_q  <= chnnl_d;
      res_q    <= res_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == S_RESP) ? gnt_q : '0;
  assign done_err     = (state_q == S_RESP) && err_q;
  assign res_out      = res_q;
  assign busy         = (state_q != S_IDLE);
  assign a2d_strt_cnv = (state_q == S_START);
  assign a2d_chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Self-checking bench for a2d_arbiter: directed scenarios then randomized traffic
// checked against a round-robin reference model (honours A2D_ARB_PRIO_EN).
module tb_a2d_arbiter;

  localparam int N  = 4;
  localparam int TO = 48;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [11:0]  req_chnnl;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         done_err;
  logic [11:0]  res_out;
  logic         busy;
  logic         a2d_strt_cnv;
  logic [2:0]   a2d_chnnl;
  logic         a2d_cnv_cmplt;
  logic [11:0]  a2d_res;

  int           errors = 0;
  int           checks = 0;
  int           rr_model = 0;
  logic [11:0]  last_res = 12'h000;

  a2d_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .gnt(gnt), .done(done), .done_err(done_err), .res_out(res_out),
    .busy(busy), .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_gnt"},   32'(gnt), 32'h0);
    checkOutput({tag, "_done"},  32'(done), 32'h0);
    checkOutput({tag, "_err"},   32'(done_err), 32'h0);
    checkOutput({tag, "_res"},   32'(res_out), 32'h0);
    checkOutput({tag, "_busy"},  32'(busy), 32'h0);
    checkOutput({tag, "_strt"},  32'(a2d_strt_cnv), 32'h0);
    checkOutput({tag, "_chnnl"}, 32'(a2d_chnnl), 32'h0);
  endtask

  // Reference rule: scan upward from the pointer, wrapping; requester 0 first when prioritised.
  function automatic int expWinner(input logic [3:0] r, input int rr);
`ifdef A2D_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // Called at a falling edge in IDLE with req nonzero; runs one whole grant.
  task automatic applyStimulus(input int d, input bit complete, input logic [11:0] rv,
                               input bit drop_own, input logic [3:0] add_req,
                               input int reset_at, input bit spurious);
    int         w;
    int         done_at;
    bit         timed_out;
    logic [3:0] oh;
    logic [2:0] ch;
    logic [11:0] exp_res;
    w         = expWinner(req, rr_model);
    oh        = 4'b0001 << w;
    ch        = req_chnnl[3*w +: 3];
    timed_out = !(complete && d >= 1 && d <= TO);
    done_at   = timed_out ? TO + 1 : d + 1;
    exp_res   = timed_out ? 12'hFFF : rv;
    @(negedge clk);
    checkOutput("start_strt",  32'(a2d_strt_cnv), 32'h1);
    checkOutput("start_gnt",   32'(gnt), 32'(oh));
    checkOutput("start_chnnl", 32'(a2d_chnnl), 32'(ch));
    checkOutput("start_busy",  32'(busy), 32'h1);
    checkOutput("start_done",  32'(done), 32'h0);
    a2d_cnv_cmplt = spurious;
    a2d_res       = 12'h5A5;
    req_chnnl     = 12'($urandom);
    for (int t = 1; t <= done_at; t++) begin
      @(negedge clk);
      if (t == reset_at) begin
        rst_n         = 1'b0;
        a2d_cnv_cmplt = 1'b0;
        #1;
        checkReset("mid_reset");
        rr_model = 0;
        last_res = 12'h000;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      checkOutput("hold_gnt",   32'(gnt), 32'(oh));
      checkOutput("hold_chnnl", 32'(a2d_chnnl), 32'(ch));
      checkOutput("hold_busy",  32'(busy), 32'h1);
      if (t < done_at) begin
        checkOutput("wait_done", 32'(done), 32'h0);
        checkOutput("wait_strt", 32'(a2d_strt_cnv), 32'h0);
        checkOutput("wait_err",  32'(done_err), 32'h0);
      end else begin
        checkOutput("resp_done", 32'(done), 32'(oh));
        checkOutput("resp_err",  32'(done_err), 32'(timed_out));
        checkOutput("resp_res",  32'(res_out), 32'(exp_res));
        last_res = exp_res;
      end
      a2d_cnv_cmplt = complete && (t == d) && (t < done_at);
      a2d_res       = (t == d) ? rv : 12'($urandom);
      if (t == 1) req = req | add_req;
    end
    a2d_cnv_cmplt = 1'b0;
    if (drop_own) req[w] = 1'b0;
`ifdef A2D_ARB_PRIO_EN
    if (w != 0) rr_model = (w + 1) % N;
`else
    rr_model = (w + 1) % N;
`endif
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_gnt",  32'(gnt), 32'h0);
    checkOutput("idle_done", 32'(done), 32'h0);
    checkOutput("idle_strt", 32'(a2d_strt_cnv), 32'h0);
    checkOutput("idle_res",  32'(res_out), 32'(last_res));
  endtask

  initial begin
    rst_n         = 1'b0;
    req           = 4'b0000;
    req_chnnl     = 12'h000;
    a2d_cnv_cmplt = 1'b0;
    a2d_res       = 12'h000;
    @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'h0);

    // Single request on channel 5, completing 40 clocks after the start strobe.
    req       = 4'b0010;
    req_chnnl = 12'($urandom);
    req_chnnl[5:3] = 3'd5;
    applyStimulus(40, 1'b1, 12'hABC, 1'b1, 4'b0000, 0, 1'b1);

    // Converter never answers: watchdog abort, then coincident completion on the last cycle.
    req = 4'b1000;
    applyStimulus(TO + 5, 1'b0, 12'h000, 1'b1, 4'b0000, 0, 1'b0);
    req = 4'b0100;
    applyStimulus(TO, 1'b1, 12'h3C7, 1'b1, 4'b0000, 0, 1'b0);

    // Reset while waiting; pending requests re-arbitrate from pointer 0.
    req = 4'b1010;
    applyStimulus(20, 1'b1, 12'h777, 1'b1, 4'b0000, 5, 1'b0);
    applyStimulus(7, 1'b1, 12'h246, 1'b1, 4'b0000, 0, 1'b0);
    applyStimulus(3, 1'b1, 12'h135, 1'b1, 4'b0000, 0, 1'b0);

    // Full contention with drop after done, then continuous re-request.
    req = 4'b1111;
    for (int i = 0; i < 4; i++)
      applyStimulus(2 + i, 1'b1, 12'(16'h100 + i), 1'b1, 4'b0000, 0, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 8; i++)
      applyStimulus(1 + i, 1'b1, 12'(16'h200 + i), 1'b0, 4'b0000, 0, 1'b0);
    req = 4'b0000;
    @(negedge clk);

    // Completion strobes while idle must not disturb anything.
    a2d_cnv_cmplt = 1'b1;
    a2d_res       = 12'h123;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stray_done", 32'(done), 32'h0);
      checkOutput("stray_busy", 32'(busy), 32'h0);
      checkOutput("stray_res",  32'(res_out), 32'(last_res));
    end
    a2d_cnv_cmplt = 1'b0;

`ifdef A2D_ARB_PRIO_EN
    rst_n = 1'b0;
    #1;
    checkReset("prio_reset");
    rr_model = 0;
    last_res = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    applyStimulus(10, 1'b1, 12'h111, 1'b1, 4'b0001, 0, 1'b0);
    applyStimulus(10, 1'b1, 12'h222, 1'b1, 4'b0000, 0, 1'b0);
    applyStimulus(10, 1'b1, 12'h333, 1'b1, 4'b0000, 0, 1'b0);
`endif

    // Randomized traffic, including timeouts and late requests.
    for (int i = 0; i < 40; i++) begin
      if (req == 4'b0000) req = 4'($urandom_range(1, 15));
      req_chnnl = 12'($urandom);
      applyStimulus($urandom_range(1, TO + 3), $urandom_range(0, 7) != 0,
                    12'($urandom), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/a2d_arbiter.md
Name: a2d_arbiter

Overview:
- Shares the single A2D_intf SPI converter (chnnl/strt_cnv/cnv_cmplt/res) between NUM_REQ independent requesters, e.g. the IR sensor sweep, the battery monitor and diagnostics.
- Each requester posts a channel and a request. The arbiter grants requesters round-robin, sequences exactly one conversion per grant, and returns the 12-bit result with a done pulse.
- A watchdog aborts conversions that never complete.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT_CYC, 4096: clocks allowed in WAIT before the conversion is aborted; 16-bit counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester request level; hold high with req_chnnl stable until own done
- req_chnnl  input  3*NUM_REQ  channel of requester i in bits [3i+2:3i]
- gnt  output  NUM_REQ  one-hot owner, high from START through RESP
- done  output  NUM_REQ  one-cycle pulse to the owner, asserted in RESP
- done_err  output  1  high with done when the conversion timed out
- res_out  output  12  last result, held until the next RESP
- busy  output  1  state != IDLE
- a2d_strt_cnv  output  1  to A2D_intf strt_cnv
- a2d_chnnl  output  3  to A2D_intf chnnl, registered, stable from START to RESP
- a2d_cnv_cmplt  input  1  from A2D_intf
- a2d_res  input  12  from A2D_intf

Behaviour:
- Reset values: state IDLE; gnt=0; done=0; done_err=0; res_out=12'h000; busy=0; a2d_strt_cnv=0; a2d_chnnl=3'b000; rr_ptr=0; timeout counter=0. Reset asserted mid-conversion aborts immediately with no done pulse; requesters must re-request.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ...).
  - Register owner index, gnt one-hot and a2d_chnnl = req_chnnl of the winner; go to START.
  - If req is zero, stay in IDLE.
- START: a2d_strt_cnv=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - If a2d_cnv_cmplt: res_out <= a2d_res; go to RESP.
  - Else if the counter reaches TIMEOUT_CYC-1: res_out <= 12'hFFF; set err flag; go to RESP.
  - Else increment the counter.
  - a2d_cnv_cmplt takes priority when it coincides with the timeout.
- RESP:
  - done[owner]=1 and done_err=err for one cycle.
  - rr_ptr <= owner+1, wrapping to 0 past NUM_REQ-1.
  - Clear err; go to IDLE. gnt clears on leaving RESP.
- Latency: a req sampled high in IDLE at cycle 0 gives a2d_strt_cnv in cycle 1. a2d_cnv_cmplt in cycle k gives done and the new res_out in cycle k+1. Minimum idle gap between conversions is 1 cycle (IDLE).
- Handshake:
  - The requester drops req in the cycle after it sees done.
  - If req is still high in IDLE, it counts as a new request but has the lowest round-robin priority, so there is no starvation.
  - req deasserted while granted is ignored; the conversion completes and done still pulses.
  - req_chnnl changes after grant have no effect.
- a2d_cnv_cmplt outside WAIT is ignored.

Optional Feature:
- Macro A2D_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. If req[0] is high in IDLE it always wins regardless of rr_ptr, and rr_ptr is not updated after a requester-0 grant. The remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters, as described in Behaviour.

Test Plan:
- Single request: req=4'b0010, req_chnnl[5:3]=3'd5, model returns 12'hABC after 40 clocks -> a2d_chnnl=5, one strt_cnv pulse, done=4'b0010 one cycle, res_out=12'hABC, done_err=0, rr_ptr=2.
- Contention: req=4'b1111 held, each requester dropping req after its own done -> grant order 0,1,2,3, each with exactly one strt_cnv; with continuous re-request the order repeats 0,1,2,3.
- Timeout: TIMEOUT_CYC=16, model never completes -> done pulses 17 cycles after strt_cnv (1 WAIT-entry cycle + 16 counted), done_err=1, res_out=12'hFFF; next grant proceeds normally.
- Coincident completion: a2d_cnv_cmplt on the exact timeout cycle -> done_err=0, res_out=a2d_res.
- Reset mid-WAIT: drop rst_n during WAIT -> outputs return to reset values at once, no done pulse; after release, the pending req re-arbitrates from rr_ptr=0.
- A2D_ARB_PRIO_EN defined: req=4'b0110 is granted to 1; req[0] rises during that conversion -> next grant goes to 0, then 2.
